// File: rtl/mwc_pkg.sv
// Shared encodings for the data-memory write checker: entry modes, FSM states, fail codes.
package mwc_pkg;

    localparam logic [1:0] MODE_OFF = 2'b00;
    localparam logic [1:0] MODE_AD  = 2'b01;
    localparam logic [1:0] MODE_D   = 2'b10;
    localparam logic [1:0] MODE_A   = 2'b11;

    localparam logic [1:0] S_IDLE = 2'b00;
    localparam logic [1:0] S_RUN  = 2'b01;
    localparam logic [1:0] S_PASS = 2'b10;
    localparam logic [1:0] S_FAIL = 2'b11;

    localparam logic [1:0] FAIL_NONE     = 2'b00;
    localparam logic [1:0] FAIL_MISMATCH = 2'b01;
    localparam logic [1:0] FAIL_TIMEOUT  = 2'b10;

endpackage

// File: rtl/mwc_entry_match.sv
// Combinational compare of one expected-write table entry against the core store bus.
module mwc_entry_match
    import mwc_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] exp_addr,
    input  logic [WIDTH-1:0] exp_data,
    input  logic [WIDTH-1:0] dataadr,
    input  logic [WIDTH-1:0] writedata,
    output logic             match_c
);

    logic addr_eq;
    logic data_eq;

    assign addr_eq = (dataadr == exp_addr);
    assign data_eq = (writedata == exp_data);

    always_comb begin
        match_c = 1'b0;
        case (mode)
            MODE_AD: match_c = addr_eq && data_eq;
            MODE_D:  match_c = data_eq;
            MODE_A:  match_c = addr_eq;
            default: match_c = 1'b0;
        endcase
    end

endmodule

// File: rtl/mem_write_checker.sv
// Self-check monitor for the core data-memory write port: programmable expected-write
// table with ordered/unordered matching, optional strict abort and a cycle timeout.
module mem_write_checker
    import mwc_pkg::*;
#(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned NUM_CHECKS = 4,
    parameter int unsigned CNT_W      = 24,
    parameter int unsigned MISS_W     = 8,
    localparam int unsigned IDX_W     = (NUM_CHECKS > 1) ? $clog2(NUM_CHECKS) : 1
) (
    input  logic                  ph1,
    input  logic                  reset_b,
    input  logic                  start,
    input  logic                  cfg_we,
    input  logic [IDX_W-1:0]      cfg_idx,
    input  logic [1:0]            cfg_mode,
    input  logic [WIDTH-1:0]      cfg_addr,
    input  logic [WIDTH-1:0]      cfg_data,
    input  logic                  ordered,
    input  logic                  strict,
    input  logic [CNT_W-1:0]      timeout_cycles,
    input  logic                  memwrite,
    input  logic [WIDTH-1:0]      dataadr,
    input  logic [WIDTH-1:0]      writedata,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [1:0]            fail_code,
    output logic [NUM_CHECKS-1:0] hit_vec,
    output logic [MISS_W-1:0]     miss_count,
    output logic [CNT_W-1:0]      cycle_count
);

    localparam int unsigned PTR_W = $clog2(NUM_CHECKS + 1);

    logic [1:0]       mode_q [NUM_CHECKS];
    logic [WIDTH-1:0] addr_q [NUM_CHECKS];
    logic [WIDTH-1:0] data_q [NUM_CHECKS];

    logic [1:0]            state_q, state_d;
    logic [PTR_W-1:0]      ptr_q, ptr_d;
    logic                  ordered_q, strict_q;
    logic [CNT_W-1:0]      timeout_q;
    logic [NUM_CHECKS-1:0] hit_d, sel, match_vec, enabled;
    logic [MISS_W-1:0]     miss_d;
    logic [CNT_W-1:0]      cyc_d;
    logic [1:0]            fail_d;
    logic                  cand_seen, miss, all_hit;

    // Table is only writable outside a run; out-of-range indices are dropped.
    always_ff @(posedge ph1 or negedge reset_b) begin
        if (!reset_b) begin
            for (int i = 0; i < int'(NUM_CHECKS); i++) begin
                mode_q[i] <= MODE_OFF;
                addr_q[i] <= '0;
                data_q[i] <= '0;
            end
        end else if (cfg_we && state_q != S_RUN && 32'(cfg_idx) < NUM_CHECKS) begin
            mode_q[cfg_idx] <= cfg_mode;
            addr_q[cfg_idx] <= cfg_addr;
            data_q[cfg_idx] <= cfg_data;
        end
    end

    for (genvar g = 0; g < int'(NUM_CHECKS); g++) begin : g_entry
        mwc_entry_match #(.WIDTH(WIDTH)) u_match (
            .mode      (mode_q[g]),
            .exp_addr  (addr_q[g]),
            .exp_data  (data_q[g]),
            .dataadr   (dataadr),
            .writedata (writedata),
            .match_c   (match_vec[g])
        );
        assign enabled[g] = (mode_q[g] != MODE_OFF);
    end

    always_ff @(posedge ph1 or negedge reset_b) begin
        if (!reset_b) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    // Next state plus next values of the run bookkeeping registers.
    always_comb begin
        state_d   = state_q;
        hit_d     = hit_vec;
        miss_d    = miss_count;
        cyc_d     = cycle_count;
        ptr_d     = ptr_q;
        fail_d    = fail_code;
        sel       = '0;
        cand_seen = 1'b0;
        miss      = 1'b0;
        all_hit   = 1'b0;
        case (state_q)
            S_RUN: begin
                if (cycle_count != '1) cyc_d = cycle_count + CNT_W'(1);
                if (memwrite) begin
                    if (ordered_q) begin
                        for (int i = 0; i < int'(NUM_CHECKS); i++) begin
                            if (!cand_seen && PTR_W'(i) >= ptr_q && enabled[i] && !hit_vec[i]) begin
                                cand_seen = 1'b1;
                                if (match_vec[i]) begin
                                    sel[i] = 1'b1;
                                    ptr_d  = PTR_W'(i + 1);
                                end
                            end
                        end
                    end else begin
                        for (int i = 0; i < int'(NUM_CHECKS); i++) begin
                            if (!cand_seen && match_vec[i] && !hit_vec[i]) begin
                                cand_seen = 1'b1;
                                sel[i]    = 1'b1;
                            end
                        end
                    end
                end
                hit_d   = hit_vec | sel;
                miss    = memwrite && (sel == '0);
                all_hit = ((hit_d & enabled) == enabled);
                if (miss && miss_count != '1) miss_d = miss_count + MISS_W'(1);
                if (all_hit) begin
                    state_d = S_PASS;
                end else if (miss && strict_q) begin
                    state_d = S_FAIL;
                    fail_d  = FAIL_MISMATCH;
                end else if (timeout_q != '0 && cycle_count == timeout_q - CNT_W'(1)) begin
                    state_d = S_FAIL;
                    fail_d  = FAIL_TIMEOUT;
                end
            end
            default: begin
                if (start) begin
                    state_d = S_RUN;
                    hit_d   = '0;
                    miss_d  = '0;
                    cyc_d   = '0;
                    ptr_d   = '0;
                    fail_d  = FAIL_NONE;
                end
            end
        endcase
    end

    always_ff @(posedge ph1 or negedge reset_b) begin
        if (!reset_b) begin
            busy        <= 1'b0;
            done        <= 1'b0;
            pass        <= 1'b0;
            fail_code   <= FAIL_NONE;
            hit_vec     <= '0;
            miss_count  <= '0;
            cycle_count <= '0;
            ptr_q       <= '0;
            ordered_q   <= 1'b0;
            strict_q    <= 1'b0;
            timeout_q   <= '0;
        end else begin
            busy        <= (state_d == S_RUN);
            done        <= (state_d == S_PASS) || (state_d == S_FAIL);
            pass        <= (state_d == S_PASS);
            fail_code   <= fail_d;
            hit_vec     <= hit_d;
            miss_count  <= miss_d;
            cycle_count <= cyc_d;
            ptr_q       <= ptr_d;
            if (state_q != S_RUN && start) begin
                ordered_q <= ordered;
                strict_q  <= strict;
                timeout_q <= timeout_cycles;
            end
        end
    end

endmodule

// File: tb/tb_mem_write_checker.sv
// Scoreboard bench for mem_write_checker: expected run results are queued at stimulus time
// and compared when done rises.
module tb_mem_write_checker;

    logic        ph1 = 1'b0;
    logic        reset_b = 1'b1;
    logic        start = 1'b0;
    logic        cfg_we = 1'b0;
    logic [1:0]  cfg_idx = '0;
    logic [1:0]  cfg_mode = '0;
    logic [31:0] cfg_addr = '0;
    logic [31:0] cfg_data = '0;
    logic        ordered = 1'b0;
    logic        strict = 1'b0;
    logic [23:0] timeout_cycles = '0;
    logic        memwrite = 1'b0;
    logic [31:0] dataadr = '0;
    logic [31:0] writedata = '0;
    logic        busy, done, pass;
    logic [1:0]  fail_code;
    logic [3:0]  hit_vec;
    logic [7:0]  miss_count;
    logic [23:0] cycle_count;

    typedef struct {
        logic        pass;
        logic [1:0]  fc;
        logic [3:0]  hv;
        logic [7:0]  mc;
        logic [23:0] cc;
    } result_t;

    result_t sb[$];
    int checks = 0;
    int errors = 0;
    logic done_prev = 1'b0;

    mem_write_checker dut (
        .ph1(ph1), .reset_b(reset_b), .start(start), .cfg_we(cfg_we), .cfg_idx(cfg_idx),
        .cfg_mode(cfg_mode), .cfg_addr(cfg_addr), .cfg_data(cfg_data), .ordered(ordered),
        .strict(strict), .timeout_cycles(timeout_cycles), .memwrite(memwrite),
        .dataadr(dataadr), .writedata(writedata), .busy(busy), .done(done), .pass(pass),
        .fail_code(fail_code), .hit_vec(hit_vec), .miss_count(miss_count),
        .cycle_count(cycle_count)
    );

    always #5 ph1 = ~ph1;

    // Scoreboard: every rising edge of done retires one queued expectation.
    always @(negedge ph1) begin
        if (done === 1'b1 && done_prev !== 1'b1) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected_done: done rose with no expected result queued");
            end else begin
                result_t e;
                e = sb.pop_front();
                if (pass !== e.pass || fail_code !== e.fc || hit_vec !== e.hv ||
                    miss_count !== e.mc || cycle_count !== e.cc) begin
                    errors++;
                    $display("FAIL sb_result: got pass=%b fc=%b hit=%b miss=%0d cyc=%0d, want pass=%b fc=%b hit=%b miss=%0d cyc=%0d",
                             pass, fail_code, hit_vec, miss_count, cycle_count,
                             e.pass, e.fc, e.hv, e.mc, e.cc);
                end
            end
        end
        done_prev = done;
    end

    task automatic tick();
        @(posedge ph1);
        #1;
    endtask

    task automatic cfg_entry(input logic [1:0] idx, input logic [1:0] mode,
                             input logic [31:0] a, input logic [31:0] d);
        cfg_we = 1'b1; cfg_idx = idx; cfg_mode = mode; cfg_addr = a; cfg_data = d;
        tick();
        cfg_we = 1'b0;
    endtask

    task automatic start_run(input logic ord, input logic str, input logic [23:0] tmo);
        ordered = ord; strict = str; timeout_cycles = tmo; start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        memwrite = 1'b1; dataadr = a; writedata = d;
        tick();
        memwrite = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit ok);
        ok = 1'b0;
        for (int n = 0; n < budget && !ok; n++) begin
            tick();
            if (done === 1'b1) ok = 1'b1;
        end
    endtask

    task automatic test_reset();
        #2 reset_b = 1'b0;
        #1;
        checks++;
        if ({busy, done, pass, fail_code, hit_vec, miss_count, cycle_count} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got busy=%b done=%b pass=%b fc=%b hit=%b miss=%0d cyc=%0d, want all 0",
                     busy, done, pass, fail_code, hit_vec, miss_count, cycle_count);
        end
        repeat (2) tick();
        reset_b = 1'b1;
        tick();
    endtask

    task automatic test_single_unordered();
        cfg_entry(2'd0, 2'b01, 32'h14, 32'd21);
        sb.push_back('{pass: 1'b1, fc: 2'b00, hv: 4'b0001, mc: 8'd0, cc: 24'd10});
        start_run(1'b0, 1'b0, 24'd0);
        repeat (9) tick();
        checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL single_busy: got busy=%b done=%b, want busy=1 done=0", busy, done);
        end
        bus_write(32'h14, 32'd21);
        checks++;
        if (pass !== 1'b1 || done !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL single_latency: got pass=%b done=%b busy=%b one cycle after write, want 1 1 0",
                     pass, done, busy);
        end
    endtask

    task automatic test_data_only();
        cfg_entry(2'd0, 2'b10, 32'h0, 32'd479001600);
        sb.push_back('{pass: 1'b1, fc: 2'b00, hv: 4'b0001, mc: 8'd1, cc: 24'd2});
        start_run(1'b0, 1'b0, 24'd0);
        bus_write(32'h20, 32'd5);
        checks++;
        if (miss_count !== 8'd1 || done !== 1'b0) begin
            errors++;
            $display("FAIL data_only_miss: got miss=%0d done=%b, want miss=1 done=0", miss_count, done);
        end
        bus_write(32'h7ffc, 32'd479001600);
        checks++;
        if (pass !== 1'b1) begin
            errors++;
            $display("FAIL data_only_pass: got pass=%b, want 1", pass);
        end
    endtask

    task automatic test_ordered();
        cfg_entry(2'd0, 2'b01, 32'h4, 32'd2);
        cfg_entry(2'd1, 2'b01, 32'h4, 32'd4);
        sb.push_back('{pass: 1'b1, fc: 2'b00, hv: 4'b0011, mc: 8'd1, cc: 24'd5});
        start_run(1'b1, 1'b0, 24'd0);
        bus_write(32'h4, 32'd4);
        bus_write(32'h4, 32'd2);
        repeat (2) tick();
        checks++;
        if (done !== 1'b0 || hit_vec !== 4'b0001 || miss_count !== 8'd1) begin
            errors++;
            $display("FAIL ordered_partial: got done=%b hit=%b miss=%0d, want done=0 hit=0001 miss=1",
                     done, hit_vec, miss_count);
        end
        bus_write(32'h4, 32'd4);
        checks++;
        if (pass !== 1'b1) begin
            errors++;
            $display("FAIL ordered_pass: got pass=%b, want 1", pass);
        end
    endtask

    task automatic test_timeout();
        bit ok;
        sb.push_back('{pass: 1'b0, fc: 2'b10, hv: 4'b0000, mc: 8'd0, cc: 24'd100});
        start_run(1'b0, 1'b0, 24'd100);
        wait_done(300, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL timeout_wait: done=%b after 300 cycles, want done=1", done);
        end
        repeat (5) tick();
        checks++;
        if (done !== 1'b1 || pass !== 1'b0 || fail_code !== 2'b10 || cycle_count !== 24'd100) begin
            errors++;
            $display("FAIL timeout_hold: got done=%b pass=%b fc=%b cyc=%0d, want 1 0 10 100",
                     done, pass, fail_code, cycle_count);
        end
    endtask

    task automatic test_complete_vs_timeout();
        sb.push_back('{pass: 1'b1, fc: 2'b00, hv: 4'b0011, mc: 8'd0, cc: 24'd20});
        start_run(1'b0, 1'b0, 24'd20);
        checks++;
        if (done !== 1'b0 || fail_code !== 2'b00 || busy !== 1'b1) begin
            errors++;
            $display("FAIL restart_clear: got done=%b fc=%b busy=%b, want 0 00 1", done, fail_code, busy);
        end
        bus_write(32'h4, 32'd2);
        repeat (18) tick();
        bus_write(32'h4, 32'd4);
        checks++;
        if (pass !== 1'b1 || fail_code !== 2'b00) begin
            errors++;
            $display("FAIL complete_beats_timeout: got pass=%b fc=%b, want 1 00", pass, fail_code);
        end
    endtask

    task automatic test_strict_mismatch();
        sb.push_back('{pass: 1'b0, fc: 2'b01, hv: 4'b0000, mc: 8'd1, cc: 24'd3});
        start_run(1'b0, 1'b1, 24'd0);
        repeat (2) tick();
        bus_write(32'h100, 32'd7);
        checks++;
        if (done !== 1'b1 || fail_code !== 2'b01) begin
            errors++;
            $display("FAIL strict_abort: got done=%b fc=%b, want 1 01", done, fail_code);
        end
    endtask

    task automatic test_strict_on_completion();
        cfg_entry(2'd0, 2'b00, 32'h0, 32'h0);
        cfg_entry(2'd1, 2'b00, 32'h0, 32'h0);
        sb.push_back('{pass: 1'b1, fc: 2'b00, hv: 4'b0000, mc: 8'd1, cc: 24'd1});
        start_run(1'b0, 1'b1, 24'd0);
        bus_write(32'h100, 32'd7);
        checks++;
        if (pass !== 1'b1 || fail_code !== 2'b00) begin
            errors++;
            $display("FAIL strict_vs_complete: got pass=%b fc=%b, want 1 00", pass, fail_code);
        end
    endtask

    task automatic test_reset_midrun();
        cfg_entry(2'd2, 2'b01, 32'h8, 32'd8);
        start_run(1'b0, 1'b0, 24'd0);
        repeat (3) tick();
        checks++;
        if (busy !== 1'b1 || cycle_count !== 24'd3) begin
            errors++;
            $display("FAIL midrun_busy: got busy=%b cyc=%0d, want 1 3", busy, cycle_count);
        end
        #2 reset_b = 1'b0;
        #1;
        checks++;
        if ({busy, done, pass, fail_code, hit_vec, miss_count, cycle_count} !== '0) begin
            errors++;
            $display("FAIL midrun_async_reset: got busy=%b done=%b pass=%b cyc=%0d, want all 0",
                     busy, done, pass, cycle_count);
        end
        repeat (3) @(posedge ph1);
        #1 reset_b = 1'b1;
        sb.push_back('{pass: 1'b1, fc: 2'b00, hv: 4'b0000, mc: 8'd0, cc: 24'd1});
        start_run(1'b0, 1'b0, 24'd0);
        tick();
        checks++;
        if (pass !== 1'b1 || hit_vec !== 4'b0000) begin
            errors++;
            $display("FAIL restart_empty_table: got pass=%b hit=%b, want 1 0000", pass, hit_vec);
        end
    endtask

    initial begin
        test_reset();
        test_single_unordered();
        test_data_only();
        test_ordered();
        test_timeout();
        test_complete_vs_timeout();
        test_strict_mismatch();
        test_strict_on_completion();
        test_reset_midrun();
        repeat (3) tick();
        checks++;
        if (sb.size() !== 0) begin
            errors++;
            $display("FAIL sb_drain: %0d expected results never retired, want 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_write_checker.md
Name: mem_write_checker

Overview:
- Synthesizable self-check monitor for the MIPS core's data-memory write port (memwrite/dataadr/writedata).
- Replaces single hard-coded "one expected write" checks with a programmable table of NUM_CHECKS expected writes.
- Supports ordered or unordered matching, an optional strict mismatch abort, and a cycle timeout.
- Sits beside the core top level in simulation and FPGA bring-up, and reports pass/fail/timeout per test run.

Parameters:
- WIDTH, 32, address and data width.
- NUM_CHECKS, 4, number of expected-write table entries (≥1).
- CNT_W, 24, width of the cycle counter and timeout value.
- MISS_W, 8, width of the saturating mismatch counter.

Ports:
- ph1 in 1: single clock, rising edge.
- reset_b in 1: reset, asynchronous, active-low.
- start in 1: begin a run; honoured only when state is not RUN.
- cfg_we in 1: write table entry; ignored in RUN.
- cfg_idx in $clog2(NUM_CHECKS): entry index for cfg_we.
- cfg_mode in 2: 00 disabled, 01 addr+data, 10 data-only, 11 addr-only.
- cfg_addr in WIDTH: expected dataadr.
- cfg_data in WIDTH: expected writedata.
- ordered in 1: 1 = entries must match in index order; sampled at start.
- strict in 1: 1 = any non-matching write fails the run; sampled at start.
- timeout_cycles in CNT_W: 0 = no timeout; sampled at start.
- memwrite in 1: core store strobe.
- dataadr in WIDTH: core store address.
- writedata in WIDTH: core store data.
- busy out 1: high in RUN.
- done out 1: level, high in PASS/FAIL, cleared by the next start.
- pass out 1: high only in PASS.
- fail_code out 2: 00 none, 01 mismatch (strict), 10 timeout.
- hit_vec out NUM_CHECKS: per-entry matched flags.
- miss_count out MISS_W: non-matching writes, saturating.
- cycle_count out CNT_W: cycles spent in RUN.

Behaviour:
- Reset (async, reset_b=0):
  - state IDLE; all outputs 0; every table entry mode=disabled, addr/data=0.
- States: IDLE, RUN, PASS, FAIL.
- IDLE/PASS/FAIL with start=1:
  - next edge clears hit_vec, miss_count, cycle_count and the ordered pointer.
  - latches ordered, strict and timeout_cycles, then enters RUN.
  - done, pass and fail_code clear on that same edge.
- RUN:
  - cycle_count increments every cycle, saturating at all-ones.
  - start and cfg_we are ignored.
- Match rule for entry i: mode≠00, hit_vec[i]=0, and
  - mode 01: dataadr==addr and writedata==data;
  - mode 10: writedata==data only;
  - mode 11: dataadr==addr only.
- Ordered mode:
  - only the first enabled unhit entry at or after the pointer is eligible.
  - on a hit, the pointer advances past it; disabled entries are skipped.
- Unordered mode: the lowest-index eligible matching entry is hit; one entry at most per write.
- memwrite=1 with no eligible match:
  - miss_count increments (saturating).
  - if strict=1, next state is FAIL with fail_code=01.
- Completion: when all enabled entries are hit, next state is PASS.
  - done and pass are visible exactly 1 cycle after the edge that sampled the final matching write.
- Timeout: in RUN with timeout_cycles≠0 and cycle_count==timeout_cycles-1 at an edge, next state is FAIL with fail_code=10.
- Same-edge priority: completion > strict mismatch > timeout.
- Start with zero enabled entries: RUN lasts one cycle, then PASS.
- cfg_we with an out-of-range cfg_idx (NUM_CHECKS not a power of 2) is ignored.
- reset_b asserted mid-run: immediate IDLE, table cleared; reconfiguration is required.
- All compares are registered-input free: combinational on port values, sampled at the ph1 edge; no internal pipelining.

Decomposition:
- Shared package mwc_pkg:
  - mode encodings (MODE_OFF, MODE_AD, MODE_D, MODE_A).
  - state enum.
  - fail-code constants (FAIL_NONE, FAIL_MISMATCH, FAIL_TIMEOUT).
- One sub-module, mwc_entry_match:
  - combinational per-entry compare of mode/addr/data against the bus.
  - instantiated NUM_CHECKS times via generate.
  - its match vector feeds the priority/ordered-pointer logic in the top.

Test Plan:
- Entry0 = {01, 0x14, 21}, unordered; core writes 0x14←21 at cycle 10 → pass=1 at cycle 11, hit_vec=0001, miss_count=0.
- Entry0 = {10, -, 479001600}, strict=0; writes 0x20←5, then 0x7ffc←479001600 → PASS, miss_count=1.
- Ordered; entry0 = {01, 0x4, 2}, entry1 = {01, 0x4, 4}; writes 4 then 2 → write 4 counts as a miss, write 2 hits entry0; no PASS. A later write of 4 → PASS.
- timeout_cycles=100, no matching write → FAIL, fail_code=10, cycle_count=100, done held until start.
- Final matching write on the same edge as timeout → PASS, fail_code=00. strict=1 plus an unmatched write on the completion edge → PASS.
- Reset_b pulsed low for 3 cycles mid-RUN → outputs 0 and state IDLE asynchronously. Restart without reconfiguring → immediate PASS (no enabled entries).
